// File: rtl/wisc_pkg.sv
// Shared ISA constants for the WISC pipeline: opcodes, branch conditions,
// D/X control-bit layout and the branch condition evaluator.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    localparam int DX_CTRL_W    = 8;
    localparam int CTRL_ALUSRC  = 0;
    localparam int CTRL_MEM2REG = 1;
    localparam int CTRL_PCS     = 2;
    localparam int CTRL_REG_WR  = 3;
    localparam int CTRL_MEM_WR  = 4;
    localparam int CTRL_MEM_RD  = 5;
    localparam int CTRL_FLAG_EN = 6;
    localparam int CTRL_HALT    = 7;

    // flags = {Z, V, N}
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
        logic z, v, n;
        z = flags[2];
        v = flags[1];
        n = flags[0];
        case (cond)
            COND_NE: cond_met = !z;
            COND_EQ: cond_met = z;
            COND_GT: cond_met = !z && !n;
            COND_LT: cond_met = n;
            COND_GE: cond_met = z || !n;
            COND_LE: cond_met = n || z;
            COND_OV: cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/decode_hazard_unit.sv
// Combinational hazard detection for the decode stage: load-use, flag and
// branch-register stalls, plus the BR target forward select from MEM.
module decode_hazard_unit
    import wisc_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int BR_DATA_FWD = 1
) (
    input  logic              fd_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic              is_br,
    input  logic              flag_dep,
    input  logic [REG_AW-1:0] ex_wr_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_flag_en,
    input  logic [REG_AW-1:0] mem_wr_reg,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    output logic              stall,
    output logic              br_fwd
);

    logic load_use;
    logic flag_haz;
    logic mem_hit;
    logic br_ex_haz;
    logic br_mem_haz;

    // Hazard terms and forward select
    always_comb begin
        load_use   = ex_mem_read && (ex_wr_reg != '0) &&
                     ((use_rs && (rs == ex_wr_reg)) || (use_rt && (rt == ex_wr_reg)));
        flag_haz   = flag_dep && ex_flag_en;
        mem_hit    = mem_reg_write && (mem_wr_reg != '0) && (rs == mem_wr_reg);
        br_ex_haz  = is_br && ex_reg_write && (ex_wr_reg != '0) && (rs == ex_wr_reg);
        br_mem_haz = is_br && mem_hit && (mem_mem_read || (BR_DATA_FWD == 0));
        stall      = fd_valid && (load_use || flag_haz || br_ex_haz || br_mem_haz);
        // A loaded value is not yet in mem_alu_result, so loads never forward
        br_fwd     = is_br && mem_hit && !mem_mem_read && (BR_DATA_FWD != 0);
    end

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage: control decode, 2R1W register file with write bypass,
// branch resolution, hazard stalls, halt latch and the D/X pipeline register.
module decode_hazard_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 4,
    parameter int BR_DATA_FWD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fd_valid,
    input  logic [DATA_W-1:0]    fd_pc_plus_2,
    input  logic [15:0]          fd_instr,
    input  logic [2:0]           flags,
    input  logic [REG_AW-1:0]    ex_wr_reg,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic                 ex_flag_en,
    input  logic [REG_AW-1:0]    mem_wr_reg,
    input  logic                 mem_reg_write,
    input  logic                 mem_mem_read,
    input  logic [DATA_W-1:0]    mem_alu_result,
    input  logic [REG_AW-1:0]    wb_wr_reg,
    input  logic                 wb_reg_write,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 stall_fd,
    output logic                 flush_fd,
    output logic [DATA_W-1:0]    branch_target,
    output logic                 halt_out,
    output logic                 dx_valid,
    output logic [DATA_W-1:0]    dx_pc_plus_2,
    output logic [DATA_W-1:0]    dx_rs_data,
    output logic [DATA_W-1:0]    dx_rt_data,
    output logic [DATA_W-1:0]    dx_imm,
    output logic [REG_AW-1:0]    dx_rs,
    output logic [REG_AW-1:0]    dx_rt,
    output logic [REG_AW-1:0]    dx_rd,
    output logic [3:0]           dx_opcode,
    output logic [DX_CTRL_W-1:0] dx_ctrl
);

    localparam int unsigned NREG = 1 << REG_AW;

    logic [DATA_W-1:0]    rf [NREG];

    logic [3:0]           opcode;
    logic [2:0]           cond;
    logic                 is_b, is_br, is_hlt;
    logic                 use_rs, use_rt, flag_dep;
    logic [REG_AW-1:0]    rs, rt, rd;
    logic [DATA_W-1:0]    rs_data, rt_data, imm;
    logic [DATA_W-1:0]    b_target;
    logic [DX_CTRL_W-1:0] ctrl;
    logic                 haz_stall, br_fwd, taken, issue;

    // Field extraction, control decode and immediate generation
    always_comb begin
        opcode   = fd_instr[15:12];
        cond     = fd_instr[11:9];
        is_b     = (opcode == OP_B);
        is_br    = (opcode == OP_BR);
        is_hlt   = (opcode == OP_HLT);
        flag_dep = (is_b || is_br) && (cond != COND_AL);
        rs       = ((opcode == OP_LLB) || (opcode == OP_LHB)) ? fd_instr[11:8] : fd_instr[7:4];
        rt       = ((opcode == OP_LW)  || (opcode == OP_SW))  ? fd_instr[11:8] : fd_instr[3:0];
        rd       = fd_instr[11:8];
        ctrl     = '0;
        imm      = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_XOR: begin
                ctrl[CTRL_REG_WR]  = 1'b1;
                ctrl[CTRL_FLAG_EN] = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_RED, OP_PADDSB: begin
                ctrl[CTRL_REG_WR] = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ctrl[CTRL_REG_WR]  = 1'b1;
                ctrl[CTRL_FLAG_EN] = 1'b1;
                ctrl[CTRL_ALUSRC]  = 1'b1;
                imm    = {{(DATA_W-4){1'b0}}, fd_instr[3:0]};
                use_rs = 1'b1;
            end
            OP_LW: begin
                ctrl[CTRL_MEM_RD]  = 1'b1;
                ctrl[CTRL_REG_WR]  = 1'b1;
                ctrl[CTRL_MEM2REG] = 1'b1;
                ctrl[CTRL_ALUSRC]  = 1'b1;
                imm    = {{(DATA_W-4){fd_instr[3]}}, fd_instr[3:0]} << 1;
                use_rs = 1'b1;
            end
            OP_SW: begin
                ctrl[CTRL_MEM_WR] = 1'b1;
                ctrl[CTRL_ALUSRC] = 1'b1;
                imm    = {{(DATA_W-4){fd_instr[3]}}, fd_instr[3:0]} << 1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                ctrl[CTRL_REG_WR] = 1'b1;
                ctrl[CTRL_ALUSRC] = 1'b1;
                imm    = {{(DATA_W-8){1'b0}}, fd_instr[7:0]};
                use_rs = 1'b1;
            end
            OP_BR: begin
                use_rs = 1'b1;
            end
            OP_PCS: begin
                ctrl[CTRL_REG_WR] = 1'b1;
                ctrl[CTRL_PCS]    = 1'b1;
            end
            OP_HLT: begin
                ctrl[CTRL_HALT] = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file reads: R0 is hardwired zero, same-cycle writes bypass
    always_comb begin
        rs_data = rf[rs];
        rt_data = rf[rt];
        if (wb_reg_write && (wb_wr_reg != '0) && (wb_wr_reg == rs)) rs_data = wb_data;
        if (wb_reg_write && (wb_wr_reg != '0) && (wb_wr_reg == rt)) rt_data = wb_data;
        if (rs == '0) rs_data = '0;
        if (rt == '0) rt_data = '0;
    end

    decode_hazard_unit #(
        .REG_AW      (REG_AW),
        .BR_DATA_FWD (BR_DATA_FWD)
    ) u_hazard (
        .fd_valid      (fd_valid),
        .rs            (rs),
        .rt            (rt),
        .use_rs        (use_rs),
        .use_rt        (use_rt),
        .is_br         (is_br),
        .flag_dep      (flag_dep),
        .ex_wr_reg     (ex_wr_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_flag_en    (ex_flag_en),
        .mem_wr_reg    (mem_wr_reg),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .stall         (haz_stall),
        .br_fwd        (br_fwd)
    );

    // Branch resolution and front-end control; halt outranks stall outranks flush
    always_comb begin
        b_target      = fd_pc_plus_2 + ({{(DATA_W-9){fd_instr[8]}}, fd_instr[8:0]} << 1);
        branch_target = is_br ? (br_fwd ? mem_alu_result : rs_data) : b_target;
        taken         = fd_valid && (is_b || is_br) && cond_met(cond, flags);
        issue         = fd_valid && !halt_out && !haz_stall;
        stall_fd      = !rst && (halt_out || haz_stall);
        flush_fd      = !rst && !halt_out && !haz_stall && taken;
    end

    // Register file write port with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_reg_write && (wb_wr_reg != '0)) begin
            rf[wb_wr_reg] <= wb_data;
        end
    end

    // Sticky halt latch, set when HLT issues
    always_ff @(posedge clk) begin
        if (rst)
            halt_out <= 1'b0;
        else if (issue && is_hlt)
            halt_out <= 1'b1;
    end

    // D/X pipeline register; anything not issued becomes an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            dx_valid     <= 1'b0;
            dx_pc_plus_2 <= '0;
            dx_rs_data   <= '0;
            dx_rt_data   <= '0;
            dx_imm       <= '0;
            dx_rs        <= '0;
            dx_rt        <= '0;
            dx_rd        <= '0;
            dx_opcode    <= '0;
            dx_ctrl      <= '0;
        end else begin
            dx_valid     <= 1'b1;
            dx_pc_plus_2 <= fd_pc_plus_2;
            dx_rs_data   <= rs_data;
            dx_rt_data   <= rt_data;
            dx_imm       <= imm;
            dx_rs        <= rs;
            dx_rt        <= rt;
            dx_rd        <= rd;
            dx_opcode    <= opcode;
            dx_ctrl      <= ctrl;
        end
    end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed bench for decode_hazard_stage; a second instance runs with
// BR forwarding disabled to cover the stall-until-WB path.
module tb_decode_hazard_stage;

    logic        clk;
    logic        rst;
    logic        fd_valid;
    logic [15:0] fd_pc_plus_2;
    logic [15:0] fd_instr;
    logic [2:0]  flags;
    logic [3:0]  ex_wr_reg;
    logic        ex_reg_write, ex_mem_read, ex_flag_en;
    logic [3:0]  mem_wr_reg;
    logic        mem_reg_write, mem_mem_read;
    logic [15:0] mem_alu_result;
    logic [3:0]  wb_wr_reg;
    logic        wb_reg_write;
    logic [15:0] wb_data;

    logic        stall_fd, flush_fd, halt_out, dx_valid;
    logic [15:0] branch_target, dx_pc_plus_2, dx_rs_data, dx_rt_data, dx_imm;
    logic [3:0]  dx_rs, dx_rt, dx_rd, dx_opcode;
    logic [7:0]  dx_ctrl;

    logic        n_stall_fd, n_flush_fd, n_halt_out, n_dx_valid;
    logic [15:0] n_branch_target, n_dx_pc_plus_2, n_dx_rs_data, n_dx_rt_data, n_dx_imm;
    logic [3:0]  n_dx_rs, n_dx_rt, n_dx_rd, n_dx_opcode;
    logic [7:0]  n_dx_ctrl;

    int passed = 0;
    int total  = 0;

    decode_hazard_stage #(.DATA_W(16), .REG_AW(4), .BR_DATA_FWD(1)) dut (
        .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_pc_plus_2(fd_pc_plus_2),
        .fd_instr(fd_instr), .flags(flags), .ex_wr_reg(ex_wr_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_flag_en(ex_flag_en),
        .mem_wr_reg(mem_wr_reg), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_alu_result(mem_alu_result), .wb_wr_reg(wb_wr_reg), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .stall_fd(stall_fd), .flush_fd(flush_fd),
        .branch_target(branch_target), .halt_out(halt_out), .dx_valid(dx_valid),
        .dx_pc_plus_2(dx_pc_plus_2), .dx_rs_data(dx_rs_data), .dx_rt_data(dx_rt_data),
        .dx_imm(dx_imm), .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rd(dx_rd),
        .dx_opcode(dx_opcode), .dx_ctrl(dx_ctrl)
    );

    decode_hazard_stage #(.DATA_W(16), .REG_AW(4), .BR_DATA_FWD(0)) dut_nf (
        .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_pc_plus_2(fd_pc_plus_2),
        .fd_instr(fd_instr), .flags(flags), .ex_wr_reg(ex_wr_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_flag_en(ex_flag_en),
        .mem_wr_reg(mem_wr_reg), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_alu_result(mem_alu_result), .wb_wr_reg(wb_wr_reg), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .stall_fd(n_stall_fd), .flush_fd(n_flush_fd),
        .branch_target(n_branch_target), .halt_out(n_halt_out), .dx_valid(n_dx_valid),
        .dx_pc_plus_2(n_dx_pc_plus_2), .dx_rs_data(n_dx_rs_data), .dx_rt_data(n_dx_rt_data),
        .dx_imm(n_dx_imm), .dx_rs(n_dx_rs), .dx_rt(n_dx_rt), .dx_rd(n_dx_rd),
        .dx_opcode(n_dx_opcode), .dx_ctrl(n_dx_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // step past the next rising edge; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        ex_wr_reg = '0; ex_reg_write = 0; ex_mem_read = 0; ex_flag_en = 0;
        mem_wr_reg = '0; mem_reg_write = 0; mem_mem_read = 0; mem_alu_result = '0;
        wb_wr_reg = '0; wb_reg_write = 0; wb_data = '0;
    endtask

    initial begin
        rst = 1; flags = '0; clear_pipe();
        // load-use hazard presented while in reset: must not stall
        fd_valid = 1; fd_instr = 16'h0132; fd_pc_plus_2 = 16'h0004;
        ex_mem_read = 1; ex_reg_write = 1; ex_wr_reg = 4'd3;
        #1;
        chk("rst_stall", 32'(stall_fd), 0);
        chk("rst_flush", 32'(flush_fd), 0);
        tick(); tick();
        chk("rst_dx_valid", 32'(dx_valid), 0);
        chk("rst_halt", 32'(halt_out), 0);
        chk("rst_dx_ctrl", 32'(dx_ctrl), 0);
        chk("rst_dx_pc", 32'(dx_pc_plus_2), 0);

        // 1) load-use stall on ADD R1,R3,R2
        rst = 0; #1;
        chk("lu_stall", 32'(stall_fd), 1);
        chk("lu_flush", 32'(flush_fd), 0);
        tick();
        chk("lu_bubble", 32'(dx_valid), 0);
        clear_pipe(); #1;
        chk("lu_release", 32'(stall_fd), 0);
        tick();
        chk("add_valid", 32'(dx_valid), 1);
        chk("add_rs", 32'(dx_rs), 3);
        chk("add_rt", 32'(dx_rt), 2);
        chk("add_rd", 32'(dx_rd), 1);
        chk("add_ctrl", 32'(dx_ctrl), 32'h48);
        chk("add_pc", 32'(dx_pc_plus_2), 32'h0004);

        // SLL does not read rt, so a load into R3 does not stall it
        fd_instr = 16'h4123; ex_mem_read = 1; ex_reg_write = 1; ex_wr_reg = 4'd3; #1;
        chk("sll_nostall", 32'(stall_fd), 0);
        tick();
        chk("sll_imm", 32'(dx_imm), 3);
        chk("sll_ctrl", 32'(dx_ctrl), 32'h49);
        chk("sll_opcode", 32'(dx_opcode), 4);
        // load into R0 never stalls
        fd_instr = 16'h0102; ex_wr_reg = 4'd0; #1;
        chk("lu_r0_nostall", 32'(stall_fd), 0);
        clear_pipe();
        tick();

        // LW R1,R2,-2 and LLB R7,0xAB immediates
        fd_instr = 16'h812E; tick();
        chk("lw_imm", 32'(dx_imm), 32'hFFFC);
        chk("lw_rt", 32'(dx_rt), 1);
        chk("lw_rs", 32'(dx_rs), 2);
        chk("lw_ctrl", 32'(dx_ctrl), 32'h2B);
        fd_instr = 16'hA7AB; tick();
        chk("llb_imm", 32'(dx_imm), 32'h00AB);
        chk("llb_rs", 32'(dx_rs), 7);
        chk("llb_ctrl", 32'(dx_ctrl), 32'h09);
        fd_valid = 0; #1;
        chk("inv_stall", 32'(stall_fd), 0);
        tick();
        chk("inv_bubble", 32'(dx_valid), 0);

        // 2) B EQ off=-3 waits for flags, then taken
        fd_valid = 1; fd_instr = 16'hC3FD; fd_pc_plus_2 = 16'h0010; ex_flag_en = 1; flags = 3'b000; #1;
        chk("flag_stall", 32'(stall_fd), 1);
        chk("flag_noflush", 32'(flush_fd), 0);
        tick();
        chk("flag_bubble", 32'(dx_valid), 0);
        ex_flag_en = 0; flags = 3'b100; #1;
        chk("beq_stall", 32'(stall_fd), 0);
        chk("beq_flush", 32'(flush_fd), 1);
        chk("beq_target", 32'(branch_target), 32'h000A);
        tick();
        chk("beq_dx_valid", 32'(dx_valid), 1);
        chk("beq_dx_ctrl", 32'(dx_ctrl), 0);
        flags = 3'b000; #1;
        chk("beq_not_taken", 32'(flush_fd), 0);
        fd_instr = 16'hC400; flags = 3'b000; #1;
        chk("bgt_taken", 32'(flush_fd), 1);
        flags = 3'b001; #1;
        chk("bgt_not_taken", 32'(flush_fd), 0);
        fd_instr = 16'hCE02; fd_pc_plus_2 = 16'hFFFE; #1;
        chk("b_wrap_flush", 32'(flush_fd), 1);
        chk("b_wrap_target", 32'(branch_target), 32'h0002);
        tick();

        // 3) RF bypass and R0
        fd_instr = 16'h0150; fd_pc_plus_2 = 16'h0020;
        wb_reg_write = 1; wb_wr_reg = 4'd5; wb_data = 16'hBEEF;
        tick();
        chk("bypass_rs", 32'(dx_rs_data), 32'hBEEF);
        chk("bypass_rt_r0", 32'(dx_rt_data), 0);
        wb_reg_write = 0; fd_instr = 16'h1255; tick();
        chk("stored_rs", 32'(dx_rs_data), 32'hBEEF);
        chk("stored_rt", 32'(dx_rt_data), 32'hBEEF);
        wb_reg_write = 1; wb_wr_reg = 4'd0; wb_data = 16'h1234; fd_instr = 16'h0100; tick();
        chk("r0_bypass", 32'(dx_rs_data), 0);
        wb_reg_write = 0; tick();
        chk("r0_read", 32'(dx_rs_data), 0);

        // 4) BR always R4 with writer in MEM
        fd_instr = 16'hDE40; mem_wr_reg = 4'd4; mem_reg_write = 1; mem_alu_result = 16'h0120; #1;
        chk("brfwd_stall", 32'(stall_fd), 0);
        chk("brfwd_flush", 32'(flush_fd), 1);
        chk("brfwd_target", 32'(branch_target), 32'h0120);
        chk("brnf_stall", 32'(n_stall_fd), 1);
        chk("brnf_flush", 32'(n_flush_fd), 0);
        tick();
        chk("brfwd_dx_valid", 32'(dx_valid), 1);
        chk("brfwd_dx_ctrl", 32'(dx_ctrl), 0);
        chk("brnf_bubble", 32'(n_dx_valid), 0);
        clear_pipe(); #1;
        chk("brnf_release", 32'(n_stall_fd), 0);
        chk("brnf_flush2", 32'(n_flush_fd), 1);
        chk("brnf_target", 32'(n_branch_target), 0);
        // BR with the writer still in EX stalls even with forwarding
        ex_reg_write = 1; ex_wr_reg = 4'd4; #1;
        chk("br_ex_stall", 32'(stall_fd), 1);
        clear_pipe();
        tick();

        // 5) HLT latches and holds the front end
        fd_instr = 16'hF000; #1;
        chk("hlt_nostall", 32'(stall_fd), 0);
        tick();
        chk("hlt_halt", 32'(halt_out), 1);
        chk("hlt_dx_valid", 32'(dx_valid), 1);
        chk("hlt_dx_ctrl", 32'(dx_ctrl), 32'h80);
        fd_instr = 16'h0132; #1;
        chk("halted_stall", 32'(stall_fd), 1);
        tick();
        chk("halted_bubble", 32'(dx_valid), 0);
        chk("halted_sticky", 32'(halt_out), 1);
        fd_instr = 16'hCE02; #1;
        chk("halted_noflush", 32'(flush_fd), 0);
        chk("halted_stall2", 32'(stall_fd), 1);
        tick();
        chk("halted_bubble2", 32'(dx_valid), 0);
        rst = 1; #1;
        chk("halt_rst_stall", 32'(stall_fd), 0);
        tick();
        chk("halt_rst_halt", 32'(halt_out), 0);
        chk("halt_rst_valid", 32'(dx_valid), 0);
        chk("halt_rst_pc", 32'(dx_pc_plus_2), 0);
        chk("halt_rst_imm", 32'(dx_imm), 0);
        rst = 0; fd_instr = 16'h0132; #1;
        chk("post_halt_stall", 32'(stall_fd), 0);
        tick();
        chk("post_halt_valid", 32'(dx_valid), 1);

        // 6) reset during a load-use stall, RF cleared
        fd_valid = 0; wb_reg_write = 1; wb_wr_reg = 4'd3; wb_data = 16'h5555; tick();
        wb_reg_write = 0; fd_valid = 1; fd_instr = 16'h0132; tick();
        chk("r3_written", 32'(dx_rs_data), 32'h5555);
        ex_mem_read = 1; ex_reg_write = 1; ex_wr_reg = 4'd3; #1;
        chk("lu2_stall", 32'(stall_fd), 1);
        rst = 1; #1;
        chk("lu2_rst_stall", 32'(stall_fd), 0);
        tick();
        chk("lu2_rst_valid", 32'(dx_valid), 0);
        rst = 0; clear_pipe(); #1;
        chk("lu2_after_stall", 32'(stall_fd), 0);
        tick();
        chk("lu2_after_valid", 32'(dx_valid), 1);
        chk("lu2_rf_cleared", 32'(dx_rs_data), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
